// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch path.
//   ADDR_W        : program counter / RAM address width
//   DATA_W        : RAM word / instruction width
//   fetch_state_t : fetch sequencer states
package proc_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched instructions and the address each came from.
// Slot 0 is always the head, so the consumer-facing outputs come straight
// from registers.
//   clk, reset_n    : clock, async active-low reset
//   flush_i         : drop all entries (a push in the same cycle is dropped too)
//   push_i          : write data_i/pc_i into the first free slot
//   pop_i           : consumer ready; only acts when the head is valid
//   data_o, pc_o    : head entry
//   full_o, empty_o : occupancy flags
module fetch_buf #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] pc_i,
    output logic [DW-1:0] data_o,
    output logic [AW-1:0] pc_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [AW-1:0] p0_q, p0_d, p1_q, p1_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic          pop;

    always_comb begin
        d0_d = d0_q;
        p0_d = p0_q;
        d1_d = d1_q;
        p1_d = p1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        pop  = pop_i & v0_q;
        if (flush_i) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            // Pop first (shift slot 1 down), then push into the first free slot;
            // this makes push+pop while full keep occupancy at two.
            if (pop) begin
                d0_d = d1_q;
                p0_d = p1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            if (push_i) begin
                if (!v0_d) begin
                    d0_d = data_i;
                    p0_d = pc_i;
                    v0_d = 1'b1;
                end else begin
                    d1_d = data_i;
                    p1_d = pc_i;
                    v1_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d0_q <= '0;
            p0_q <= '0;
            d1_q <= '0;
            p1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            d0_q <= d0_d;
            p0_q <= p0_d;
            d1_q <= d1_d;
            p1_q <= p1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign data_o  = d0_q;
    assign pc_o    = p0_q;
    assign full_o  = v1_q;
    assign empty_o = ~v0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: streams words from a synchronous-read RAM into a
// two-entry buffer with valid/ready handshake toward the consumer.
//   clk, reset_n          : clock, async active-low reset
//   en                    : run request (level)
//   jump_valid, jump_addr : redirect pc, flush buffer and in-flight read
//   ram_addr/we/data/q    : RAM port (read only; ram_q one cycle after addr)
//   instr, instr_pc       : head instruction and the address it came from
//   instr_valid/ready     : handshake; transfer = valid & ready
module fetch_unit #(
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    import proc_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              buf_full, buf_empty;
    logic              pop, push, issue;

    assign pop  = instr_valid & instr_ready;
    // A jump discards the read that is landing this cycle.
    assign push = infl_q & ~jump_valid;

    always_comb begin
        // Issue only if the in-flight read plus post-pop occupancy leaves room.
        issue     = (state_q == RUN) && !jump_valid &&
                    ((int'(infl_q) + int'(buf_full) + int'(!buf_empty) - int'(pop)) < DEPTH);
        infl_d    = issue;
        infl_pc_d = pc_q;
        pc_d      = pc_q;
        if (jump_valid)
            pc_d = jump_addr;
        else if (issue)
            pc_d = pc_q + ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            // Nothing is issued in DRAIN, so the last read lands this cycle.
            DRAIN:   if (en) state_d = RUN;
                     else if (!infl_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    // The RAM always sees pc; outside an issue cycle the read is just ignored.
    assign ram_addr = pc_q;
    assign ram_we   = 1'b0;
    assign ram_data = '0;

    fetch_buf #(.AW(ADDR_W), .DW(DATA_W)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (jump_valid),
        .push_i  (push),
        .pop_i   (instr_ready),
        .data_i  (ram_q),
        .pc_i    (infl_pc_q),
        .data_o  (instr),
        .pc_o    (instr_pc),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign instr_valid = ~buf_empty;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0;
    logic       jump_valid = 1'b0;
    logic [4:0] jump_addr = '0;
    logic [4:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_data;
    logic [7:0] ram_q = '0;
    logic [7:0] instr;
    logic [4:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;

    logic [7:0] mem [32];
    int         total = 0;
    int         bad = 0;
    logic [4:0] exp_pc;
    logic [4:0] frz;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_data    (ram_data),
        .ram_q       (ram_q),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle seen from the consumer: set ready for the coming edge, check
    // the head against the expected in-order stream, advance on a transfer.
    task automatic cyc(input logic exp_valid, input logic rdy);
        @(negedge clk);
        instr_ready = rdy;
        chk("valid", 32'(instr_valid), 32'(exp_valid));
        if (instr_valid) begin
            chk("pc", 32'(instr_pc), 32'(exp_pc));
            chk("data", 32'(instr), 32'({3'b0, exp_pc} + 8'd1));
            if (rdy) exp_pc = exp_pc + 5'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
        exp_pc = '0;

        // reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("ram_we", 32'(ram_we), 32'd0);
        chk("ram_data", 32'(ram_data), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        en = 1'b1;
        instr_ready = 1'b1;

        // start-up latency then one per cycle
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);

        // 5-cycle stall: head held, fetch stops with two buffered
        cyc(1'b1, 1'b0);
        chk("full_addr0", 32'(ram_addr), 32'(5'(exp_pc + 5'd2)));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        chk("full_addr4", 32'(ram_addr), 32'(5'(exp_pc + 5'd2)));

        // resume and stream across the 31->0 wrap with no bubble
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);

        // fill, then jump with a transfer in the same cycle
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        jump_valid = 1'b1;
        jump_addr  = 5'd10;
        cyc(1'b0, 1'b1);
        jump_valid = 1'b0;
        exp_pc = 5'd10;
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);

        // en drop: last issue drains, then IDLE with ram_addr frozen
        cyc(1'b1, 1'b1);
        en = 1'b0;
        chk("drain_addr", 32'(ram_addr), 32'(5'(exp_pc + 5'd1)));
        frz = exp_pc + 5'd2;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1);
            chk("idle_addr", 32'(ram_addr), 32'(frz));
        end

        // jump while IDLE: pc moves, nothing issued until en
        jump_valid = 1'b1;
        jump_addr  = 5'd3;
        cyc(1'b0, 1'b1);
        jump_valid = 1'b0;
        chk("idle_jump_addr", 32'(ram_addr), 32'd3);
        cyc(1'b0, 1'b1);
        chk("idle_no_issue", 32'(ram_addr), 32'd3);
        en = 1'b1;
        exp_pc = 5'd3;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);

        // asynchronous reset mid-run, then restart from pc 0
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_pc", 32'(instr_pc), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_pc = '0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);

        en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
